// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module : seq_detector_param
// Brief  : Run-time configurable serial pattern detector with a saturating
//          match counter (overlapping / non-overlapping modes).
// Rev    : 1.0  initial release
// ============================================================================
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pattern_in,
    input  logic [LEN_W-1:0]   len_in,
    input  logic               overlap_in,
    input  logic               x_valid,
    input  logic               x,
    input  logic               count_clr,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   cfg_len
);

    localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;
    logic [MAX_LEN-1:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic               r_z;
    logic [CNT_W-1:0]   r_count;

    logic [LEN_W-1:0]   w_len_clamped;
    logic [MAX_LEN-1:0] w_hist_n;
    logic [LEN_W-1:0]   w_fill_n;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_match;

    always_comb begin
        w_len_clamped = len_in;
        if (len_in == '0)
            w_len_clamped = LEN_W'(1);
        else if (len_in > c_max_len)
            w_len_clamped = c_max_len;
    end

    // Only the low r_len bits of history and pattern take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            w_mask[i] = (LEN_W'(i) < r_len);
    end

    assign w_hist_n = {r_hist[MAX_LEN-2:0], x};
    assign w_fill_n = (r_fill == c_max_len) ? r_fill : r_fill + 1'b1;
    assign w_match  = x_valid && !load && (w_fill_n >= r_len) &&
                      (((w_hist_n ^ r_pattern) & w_mask) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pattern <= MAX_LEN'(5);
            r_len     <= LEN_W'(3);
            r_overlap <= 1'b0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_z       <= 1'b0;
        end else if (load) begin
            r_pattern <= pattern_in;
            r_len     <= w_len_clamped;
            r_overlap <= overlap_in;
            r_hist    <= '0;
            r_fill    <= '0;
            r_z       <= 1'b0;
        end else if (x_valid) begin
            r_hist <= w_hist_n;
            // Non-overlap mode restarts the fill so matched bits are not reused.
            r_fill <= (w_match && !r_overlap) ? '0 : w_fill_n;
            r_z    <= w_match;
        end else begin
            r_z <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || count_clr)
            r_count <= '0;
        else if (w_match && (r_count != c_cnt_max))
            r_count <= r_count + 1'b1;
    end

    assign z           = r_z;
    assign match_count = r_count;
    assign cfg_len     = r_len;

endmodule
`default_nettype wire
